// File: rtl/if_id_ctrl.sv
// IF/ID pipeline register with decode-side redirect and hazard control.
// Drives fetch redirects/stalls, ID/EX bubble insertion and saturating event counters.
module if_id_ctrl #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] instr_f,
  input  logic [WIDTH-1:0] pc_fetch_f,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic             memread_e,
  input  logic             regwrite_e,
  input  logic [4:0]       writereg_e,
  input  logic             memread_m,
  input  logic [4:0]       writereg_m,
  output logic [WIDTH-1:0] instr_d,
  output logic [WIDTH-1:0] pc_plus4_d,
  output logic             valid_d,
  output logic             pcsrc,
  output logic             jump,
  output logic [WIDTH-1:0] pc_branch,
  output logic [WIDTH-1:0] pc_jump,
  output logic             stall_pc,
  output logic             stall_d,
  output logic             flush_decode,
  output logic             flush_e,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [WIDTH-1:0] LOW28_MASK = WIDTH'(28'hFFF_FFFF);

  logic [WIDTH-1:0] instr_d_q, instr_d_d;
  logic [WIDTH-1:0] pc_plus4_d_q, pc_plus4_d_d;
  logic             valid_d_q, valid_d_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic [5:0]       op;
  logic [4:0]       rs, rt;
  logic             is_beq, is_bne, is_jmp, reads_rt;
  logic             hit_e_rs, hit_e_rt, hit_m_rs, hit_m_rt;
  logic             lwstall, brstall, stall, redirect_br, redirect_j;
  logic [WIDTH-1:0] br_off;

  always_comb begin
    op       = instr_d_q[31:26];
    rs       = instr_d_q[25:21];
    rt       = instr_d_q[20:16];
    is_beq   = (op == OP_BEQ);
    is_bne   = (op == OP_BNE);
    is_jmp   = (op == OP_J) || (op == OP_JAL);
    reads_rt = (op != OP_LW);

    hit_e_rs = (writereg_e != 5'd0) && (writereg_e == rs);
    hit_e_rt = (writereg_e != 5'd0) && (writereg_e == rt);
    hit_m_rs = (writereg_m != 5'd0) && (writereg_m == rs);
    hit_m_rt = (writereg_m != 5'd0) && (writereg_m == rt);

    lwstall = valid_d_q && memread_e && (hit_e_rs || (reads_rt && hit_e_rt));
    brstall = (is_beq || is_bne) && valid_d_q &&
              ((regwrite_e && (hit_e_rs || hit_e_rt)) ||
               (memread_m  && (hit_m_rs || hit_m_rt)));
    stall   = lwstall || brstall;

    redirect_br = valid_d_q && !stall &&
                  ((is_beq && (rd1_d == rd2_d)) || (is_bne && (rd1_d != rd2_d)));
    redirect_j  = valid_d_q && !stall && is_jmp;

    br_off = {{(WIDTH-18){instr_d_q[15]}}, instr_d_q[15:0], 2'b00};
  end

  always_comb begin
    instr_d_d    = instr_f;
    pc_plus4_d_d = pc_fetch_f;
    valid_d_d    = 1'b1;
    if (stall) begin
      instr_d_d    = instr_d_q;
      pc_plus4_d_d = pc_plus4_d_q;
      valid_d_d    = valid_d_q;
    end else if (redirect_br || redirect_j) begin
      instr_d_d    = '0;
      pc_plus4_d_d = pc_fetch_f;
      valid_d_d    = 1'b0;
    end

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    flush_cnt_d = flush_cnt_q;
    if ((redirect_br || redirect_j) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_d_q    <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      instr_d_q    <= instr_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  always_comb begin
    instr_d      = instr_d_q;
    pc_plus4_d   = pc_plus4_d_q;
    valid_d      = valid_d_q;
    stall_cnt    = stall_cnt_q;
    flush_cnt    = flush_cnt_q;
    stall_pc     = stall;
    stall_d      = stall;
    flush_e      = stall;
    pcsrc        = redirect_br;
    jump         = redirect_j;
    flush_decode = redirect_br || redirect_j;
    pc_branch    = pc_plus4_d_q + br_off;
    // Upper PC bits come from PC+4; low 28 bits from the word-aligned jump index.
    pc_jump      = (pc_plus4_d_q & ~LOW28_MASK) | WIDTH'({instr_d_q[25:0], 2'b00});
  end

endmodule

// File: tb/tb_if_id_ctrl.sv
// Directed bench for if_id_ctrl: reset, load-use, branch/jump redirects,
// branch-operand hazards, counter saturation and asynchronous reset mid-stall.
module tb_if_id_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_f, pc_fetch_f, rd1_d, rd2_d;
  logic        memread_e, regwrite_e, memread_m;
  logic [4:0]  writereg_e, writereg_m;
  logic [31:0] instr_d, pc_plus4_d, pc_branch, pc_jump;
  logic        valid_d, pcsrc, jump, stall_pc, stall_d, flush_decode, flush_e;
  logic [15:0] stall_cnt, flush_cnt;

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  always #5 clk = ~clk;

  if_id_ctrl #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_f(instr_f), .pc_fetch_f(pc_fetch_f),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .memread_e(memread_e), .regwrite_e(regwrite_e),
    .writereg_e(writereg_e), .memread_m(memread_m), .writereg_m(writereg_m),
    .instr_d(instr_d), .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .pcsrc(pcsrc),
    .jump(jump), .pc_branch(pc_branch), .pc_jump(pc_jump), .stall_pc(stall_pc),
    .stall_d(stall_d), .flush_decode(flush_decode), .flush_e(flush_e),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic test_reset();
    rst = 1'b0;
    instr_f = 32'h8C08_0004; pc_fetch_f = 32'h4;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (instr_d !== 32'h0) $display("FAIL rst_instr_d: got %h want %h", instr_d, 32'h0); else pass_cnt++;
    total_cnt++; if (pc_plus4_d !== 32'h0) $display("FAIL rst_pc_plus4_d: got %h want %h", pc_plus4_d, 32'h0); else pass_cnt++;
    total_cnt++; if (valid_d !== 1'b0) $display("FAIL rst_valid_d: got %b want 0", valid_d); else pass_cnt++;
    total_cnt++; if ({pcsrc, jump, stall_pc, stall_d, flush_decode, flush_e} !== 6'b0)
      $display("FAIL rst_ctrl: got %b want 000000", {pcsrc, jump, stall_pc, stall_d, flush_decode, flush_e}); else pass_cnt++;
    total_cnt++; if ({pc_branch, pc_jump} !== 64'h0) $display("FAIL rst_targets: got %h want 0", {pc_branch, pc_jump}); else pass_cnt++;
    total_cnt++; if ({stall_cnt, flush_cnt} !== 32'h0) $display("FAIL rst_counters: got %h want 0", {stall_cnt, flush_cnt}); else pass_cnt++;
    rst = 1'b1;
    @(posedge clk); #1;
    total_cnt++; if (instr_d !== 32'h8C08_0004) $display("FAIL rel_instr_d: got %h want %h", instr_d, 32'h8C08_0004); else pass_cnt++;
    total_cnt++; if (valid_d !== 1'b1) $display("FAIL rel_valid_d: got %b want 1", valid_d); else pass_cnt++;
    total_cnt++; if (pc_plus4_d !== 32'h4) $display("FAIL rel_pc_plus4_d: got %h want %h", pc_plus4_d, 32'h4); else pass_cnt++;
  endtask

  task automatic test_load_use();
    // ID holds lw $8,4($0): rt is a destination, rs is $0
    memread_e = 1'b1; writereg_e = 5'd8; #1;
    total_cnt++; if (stall_d !== 1'b0) $display("FAIL lw_rt_nostall: got %b want 0", stall_d); else pass_cnt++;
    writereg_e = 5'd0; #1;
    total_cnt++; if (stall_d !== 1'b0) $display("FAIL reg0_nostall: got %b want 0", stall_d); else pass_cnt++;
    memread_e = 1'b0;
    instr_f = 32'h0108_4820; pc_fetch_f = 32'h8;
    @(posedge clk); #1;
    total_cnt++; if (instr_d !== 32'h0108_4820) $display("FAIL lu_load: got %h want %h", instr_d, 32'h0108_4820); else pass_cnt++;
    memread_e = 1'b1; writereg_e = 5'd8;
    instr_f = 32'h0000_5020; pc_fetch_f = 32'hC; #1;
    total_cnt++; if ({stall_pc, stall_d, flush_e} !== 3'b111) $display("FAIL lu_stall: got %b want 111", {stall_pc, stall_d, flush_e}); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd0) $display("FAIL lu_cnt0: got %0d want 0", stall_cnt); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (instr_d !== 32'h0108_4820) $display("FAIL lu_hold: got %h want %h", instr_d, 32'h0108_4820); else pass_cnt++;
    total_cnt++; if (pc_plus4_d !== 32'h8) $display("FAIL lu_hold_pc: got %h want %h", pc_plus4_d, 32'h8); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt1: got %0d want 1", stall_cnt); else pass_cnt++;
    memread_e = 1'b0; #1;
    total_cnt++; if (stall_d !== 1'b0) $display("FAIL lu_release: got %b want 0", stall_d); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (instr_d !== 32'h0000_5020) $display("FAIL lu_resume: got %h want %h", instr_d, 32'h0000_5020); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd1) $display("FAIL lu_cnt_after: got %0d want 1", stall_cnt); else pass_cnt++;
  endtask

  task automatic test_beq();
    writereg_e = 5'd0;
    instr_f = 32'h1109_0003; pc_fetch_f = 32'h10;
    @(posedge clk); #1;
    rd1_d = 32'd5; rd2_d = 32'd5;
    instr_f = 32'hDEAD_BEEF; pc_fetch_f = 32'h14; #1;
    total_cnt++; if (pcsrc !== 1'b1) $display("FAIL beq_pcsrc: got %b want 1", pcsrc); else pass_cnt++;
    total_cnt++; if (pc_branch !== 32'h1C) $display("FAIL beq_target: got %h want %h", pc_branch, 32'h1C); else pass_cnt++;
    total_cnt++; if (flush_decode !== 1'b1) $display("FAIL beq_flush: got %b want 1", flush_decode); else pass_cnt++;
    total_cnt++; if (jump !== 1'b0) $display("FAIL beq_jump: got %b want 0", jump); else pass_cnt++;
    rd2_d = 32'd6; #1;
    total_cnt++; if ({pcsrc, flush_decode} !== 2'b00) $display("FAIL beq_nt: got %b want 00", {pcsrc, flush_decode}); else pass_cnt++;
    rd2_d = 32'd5; #1;
    @(posedge clk); #1;
    total_cnt++; if (instr_d !== 32'h0) $display("FAIL beq_squash: got %h want %h", instr_d, 32'h0); else pass_cnt++;
    total_cnt++; if (valid_d !== 1'b0) $display("FAIL beq_squash_valid: got %b want 0", valid_d); else pass_cnt++;
    total_cnt++; if (pc_plus4_d !== 32'h14) $display("FAIL beq_squash_pc: got %h want %h", pc_plus4_d, 32'h14); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 16'd1) $display("FAIL beq_flush_cnt: got %0d want 1", flush_cnt); else pass_cnt++;
  endtask

  task automatic test_jump_wrap();
    instr_f = 32'h0800_0040; pc_fetch_f = 32'h4000_0004;
    @(posedge clk); #1;
    total_cnt++; if (jump !== 1'b1) $display("FAIL j_jump: got %b want 1", jump); else pass_cnt++;
    total_cnt++; if (pc_jump !== 32'h4000_0100) $display("FAIL j_target: got %h want %h", pc_jump, 32'h4000_0100); else pass_cnt++;
    total_cnt++; if (pc_branch !== 32'h4000_0104) $display("FAIL j_brtarget: got %h want %h", pc_branch, 32'h4000_0104); else pass_cnt++;
    total_cnt++; if ({flush_decode, pcsrc} !== 2'b10) $display("FAIL j_flush: got %b want 10", {flush_decode, pcsrc}); else pass_cnt++;
    instr_f = 32'h1000_FFFF; pc_fetch_f = 32'h0;
    rd1_d = 32'd0; rd2_d = 32'd0;
    @(posedge clk); #1;
    total_cnt++; if ({instr_d, valid_d} !== 33'h0) $display("FAIL j_squash: got %h want 0", {instr_d, valid_d}); else pass_cnt++;
    total_cnt++; if (flush_cnt !== 16'd2) $display("FAIL j_flush_cnt: got %0d want 2", flush_cnt); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (pc_branch !== 32'hFFFF_FFFC) $display("FAIL wrap_target: got %h want %h", pc_branch, 32'hFFFF_FFFC); else pass_cnt++;
    total_cnt++; if (pcsrc !== 1'b1) $display("FAIL wrap_pcsrc: got %b want 1", pcsrc); else pass_cnt++;
    rd2_d = 32'd1; #1;
    total_cnt++; if (pcsrc !== 1'b0) $display("FAIL wrap_nt: got %b want 0", pcsrc); else pass_cnt++;
  endtask

  task automatic test_branch_hazard();
    instr_f = 32'h1109_0003; pc_fetch_f = 32'h10;
    @(posedge clk); #1;
    rd1_d = 32'd5; rd2_d = 32'd5;
    regwrite_e = 1'b1; writereg_e = 5'd8;
    instr_f = 32'h0000_5020; pc_fetch_f = 32'h14; #1;
    total_cnt++; if ({stall_d, stall_pc, flush_e} !== 3'b111) $display("FAIL bh_stall: got %b want 111", {stall_d, stall_pc, flush_e}); else pass_cnt++;
    total_cnt++; if ({pcsrc, flush_decode} !== 2'b00) $display("FAIL bh_gate: got %b want 00", {pcsrc, flush_decode}); else pass_cnt++;
    writereg_e = 5'd0; #1;
    total_cnt++; if ({stall_d, pcsrc} !== 2'b01) $display("FAIL bh_reg0: got %b want 01", {stall_d, pcsrc}); else pass_cnt++;
    regwrite_e = 1'b0; memread_m = 1'b1; writereg_m = 5'd9; #1;
    total_cnt++; if ({stall_d, pcsrc} !== 2'b10) $display("FAIL bh_mem: got %b want 10", {stall_d, pcsrc}); else pass_cnt++;
    memread_m = 1'b0; writereg_m = 5'd0; rd2_d = 32'd6; #1;
    total_cnt++; if ({stall_d, pcsrc, flush_decode} !== 3'b000) $display("FAIL bh_clear: got %b want 000", {stall_d, pcsrc, flush_decode}); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (instr_d !== 32'h0000_5020) $display("FAIL bh_advance: got %h want %h", instr_d, 32'h0000_5020); else pass_cnt++;
    total_cnt++; if ({stall_cnt, flush_cnt} !== {16'd1, 16'd2}) $display("FAIL bh_counts: got %h want %h", {stall_cnt, flush_cnt}, {16'd1, 16'd2}); else pass_cnt++;
  endtask

  task automatic test_saturation_reset();
    instr_f = 32'h0108_4820; pc_fetch_f = 32'h18;
    @(posedge clk); #1;
    memread_e = 1'b1; writereg_e = 5'd8;
    repeat (65539) @(posedge clk);
    #1;
    total_cnt++; if (stall_cnt !== 16'hFFFF) $display("FAIL sat_cnt: got %h want %h", stall_cnt, 16'hFFFF); else pass_cnt++;
    total_cnt++; if (instr_d !== 32'h0108_4820) $display("FAIL sat_hold: got %h want %h", instr_d, 32'h0108_4820); else pass_cnt++;
    total_cnt++; if (stall_d !== 1'b1) $display("FAIL sat_stall: got %b want 1", stall_d); else pass_cnt++;
    #2 rst = 1'b0;
    #1;
    total_cnt++; if ({instr_d, pc_plus4_d, valid_d} !== 65'h0) $display("FAIL arst_reg: got %h want 0", {instr_d, pc_plus4_d, valid_d}); else pass_cnt++;
    total_cnt++; if ({stall_cnt, flush_cnt} !== 32'h0) $display("FAIL arst_cnt: got %h want 0", {stall_cnt, flush_cnt}); else pass_cnt++;
    total_cnt++; if ({stall_d, flush_e, stall_pc} !== 3'b000) $display("FAIL arst_stall: got %b want 000", {stall_d, flush_e, stall_pc}); else pass_cnt++;
    #1 rst = 1'b1;
    memread_e = 1'b0; writereg_e = 5'd0;
    @(posedge clk); #1;
    total_cnt++; if ({instr_d, valid_d} !== {32'h0108_4820, 1'b1}) $display("FAIL arst_resume: got %h want %h", {instr_d, valid_d}, {32'h0108_4820, 1'b1}); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd0) $display("FAIL arst_cnt_after: got %0d want 0", stall_cnt); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0;
    instr_f = '0; pc_fetch_f = '0; rd1_d = '0; rd2_d = '0;
    memread_e = 1'b0; regwrite_e = 1'b0; writereg_e = '0;
    memread_m = 1'b0; writereg_m = '0;
    test_reset();
    test_load_use();
    test_beq();
    test_jump_wrap();
    test_branch_hazard();
    test_saturation_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/if_id_ctrl.md
Name: if_id_ctrl

Overview:
- Decode-side counterpart of the fetch stage.
- Holds the IF/ID pipeline register, which latches the fetched instruction and PC+4.
- Decodes beq/bne/j/jal from the latched instruction and drives the fetch stage's redirect and stall controls: pcsrc, jump, pc_branch, pc_jump, stall_pc, flush_decode.
- Detects load-use and branch-operand hazards against the EX and MEM stages, inserts bubbles into ID/EX, and keeps saturating stall/flush event counters.

Parameters:
- WIDTH, 32, datapath/PC width in bits (must be >= 28).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- instr_f  input  WIDTH  instruction from fetch.
- pc_fetch_f  input  WIDTH  PC+4 from fetch.
- rd1_d  input  WIDTH  forwarded rs value for branch compare.
- rd2_d  input  WIDTH  forwarded rt value for branch compare.
- memread_e  input  1  EX-stage instruction is a load.
- regwrite_e  input  1  EX-stage instruction writes the register file.
- writereg_e  input  5  EX-stage destination register.
- memread_m  input  1  MEM-stage instruction is a load.
- writereg_m  input  5  MEM-stage destination register.
- instr_d  output  WIDTH  latched instruction.
- pc_plus4_d  output  WIDTH  latched PC+4.
- valid_d  output  1  the ID slot holds a real instruction.
- pcsrc  output  1  take branch.
- jump  output  1  take jump.
- pc_branch  output  WIDTH  branch target.
- pc_jump  output  WIDTH  jump target.
- stall_pc  output  1  hold the PC.
- stall_d  output  1  hold IF/ID.
- flush_decode  output  1  squash the instruction currently being fetched.
- flush_e  output  1  insert a bubble into ID/EX.
- stall_cnt  output  CNT_W  cycles with stall_d=1, saturating.
- flush_cnt  output  CNT_W  cycles with flush_decode=1, saturating.

Behaviour:
- Reset (rst=0, asynchronous): instr_d=0, pc_plus4_d=0, valid_d=0, stall_cnt=0, flush_cnt=0. With these values all combinational outputs evaluate to 0. Reset asserted mid-stall or mid-flush clears the register immediately, with no pending state left.
- IF/ID register update at each rising edge, in priority order:
  - stall_d=1: hold all fields.
  - else flush_decode=1: load instr_d=0 (nop), pc_plus4_d=pc_fetch_f, valid_d=0.
  - else: load instr_f, pc_fetch_f, valid_d=1.
- Latency: one cycle from fetch to decode. All control outputs are combinational from the register contents and the hazard inputs.
- Field decode:
  - op = instr_d[31:26], rs = [25:21], rt = [20:16], imm = [15:0].
  - beq = op 6'h04, bne = op 6'h05, j = op 6'h02, jal = op 6'h03.
  - A load in ID reads rs only; all other ops are treated as reading rs and rt.
- Targets, computed every cycle regardless of op:
  - pc_branch = pc_plus4_d + (sign-extended imm << 2), modulo 2^WIDTH (wrap-around permitted).
  - pc_jump = {pc_plus4_d[WIDTH-1:28], instr_d[25:0], 2'b00}.
- Load-use stall:
  - lwstall = memread_e & writereg_e!=0 & (writereg_e==rs | writereg_e==rt).
  - Applies only if valid_d=1.
- Branch-operand stall:
  - brstall = (beq|bne) & valid_d & ((regwrite_e & writereg_e!=0 & writereg_e∈{rs,rt}) | (memread_m & writereg_m!=0 & writereg_m∈{rs,rt})).
- Stall outputs: stall_d = stall_pc = flush_e = lwstall | brstall.
- Redirects:
  - pcsrc = valid_d & ~stall_d & ((beq & rd1_d==rd2_d) | (bne & rd1_d!=rd2_d)).
  - jump = valid_d & ~stall_d & (j|jal).
  - flush_decode = pcsrc | jump.
  - No delay slot: the wrong-path fetch is squashed at the next edge.
  - Because of the ~stall_d gating, stall and redirect are mutually exclusive in the same cycle.
- Counters: increment by 1 on each edge where the respective signal is 1. They saturate at all-ones and do not wrap.
- Register $0 never causes a hazard.

Test Plan:
- Reset: hold rst=0 for 3 cycles while driving instr_f=0x8C080004 -> all outputs 0. After release, the next edge gives instr_d=0x8C080004, valid_d=1.
- Load-use: ID holds add $9,$8,$8 (0x01084820); memread_e=1, writereg_e=8 -> stall_pc=stall_d=flush_e=1, instr_d held for exactly 1 cycle, stall_cnt=1. After memread_e drops, fetch resumes.
- beq taken: instr_d=0x11090003, pc_plus4_d=0x00000010, rd1_d=rd2_d=5 -> pcsrc=1, pc_branch=0x0000001C, flush_decode=1; the next edge gives instr_d=0, valid_d=0. With rd2_d=6 -> pcsrc=0.
- Jump and wrap: instr_d=0x08000040, pc_plus4_d=0x40000004 -> jump=1, pc_jump=0x40000100. beq with imm=0xFFFF and pc_plus4_d=0x00000000 -> pc_branch=0xFFFFFFFC.
- Branch hazard: beq rs=8 in ID; regwrite_e=1, writereg_e=8 -> stall_d=1, pcsrc=0 even with equal operands. Repeat with writereg_e=0 -> no stall.
- Saturation and reset mid-stall: force stall for 2^CNT_W+3 cycles -> stall_cnt=all-ones. Assert rst mid-stall -> counters and register clear asynchronously, before the next edge.
